// File: rtl/iter_div_pkg.sv
// Shared types for the iterative divider: FSM state encoding and default width.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package iter_div_pkg;

    // Divider control states. The encodings are fixed so that other EX-stage
    // logic can decode them directly.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    localparam int DIV_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/iter_div.sv
// Radix-2 restoring divider for the EX stage, with signed/unsigned mode, a divide-by-zero fast path and cancel.
// Latency: the start is accepted in cycle 0 and ready pulses in cycle WIDTH+1. For divide-by-zero, ready pulses in cycle 1.
// Backpressure: stallreq holds IF/ID/EX while a start is being accepted or the divider is BUSY. It drops in DONE, so EX retires on the ready pulse.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   start, signed_op     division request (held by EX while stalled); 1 = DIV, 0 = DIVU
//   cancel               flush: abandon the operation in flight, block start in IDLE
//   dividend, divisor    operands, sampled when start is accepted
//   busy, ready          BUSY-state flag; one-cycle result-valid pulse
//   stallreq             stall request to CTRL
//   quotient, remainder  results for LO/HI; they are written on entry to DONE and then held
module iter_div
    import iter_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic             stallreq,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // Two's-complement negate when neg is set. This is used for operand
    // magnitude and for the result fix-up. The magnitude is kept unsigned, so
    // -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? ({WIDTH{1'b0}} - x) : x;
    endfunction

    div_state_e       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] dvd_q,       dvd_d;      // dividend bits shift out at the top; quotient bits shift in at the bottom
    logic [WIDTH-1:0] dvs_q,       dvs_d;      // divisor magnitude
    logic [WIDTH-1:0] prem_q,      prem_d;     // restored partial remainder
    logic             q_neg_q,     q_neg_d;
    logic             r_neg_q,     r_neg_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             step_bit;
    logic [WIDTH-1:0] prem_step;
    logic [WIDTH-1:0] dvd_step;

    // One restoring step. The (WIDTH+1)-bit partial remainder takes in the next
    // dividend bit. A clear sign bit on the trial difference means the subtract fits.
    always_comb begin
        partial   = {prem_q, dvd_q[WIDTH-1]};
        diff      = partial - {1'b0, dvs_q};
        step_bit  = ~diff[WIDTH];
        prem_step = step_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        dvd_step  = {dvd_q[WIDTH-2:0], step_bit};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (start && !cancel) begin
                    dvd_d   = cond_neg(dividend, signed_op & dividend[WIDTH-1]);
                    dvs_d   = cond_neg(divisor,  signed_op & divisor[WIDTH-1]);
                    q_neg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d = signed_op & dividend[WIDTH-1];
                    prem_d  = '0;
                    if (divisor == '0) begin
                        // Fast path: the result is fixed, so no iterations are needed.
                        quotient_d  = '1;
                        remainder_d = dividend;
                        state_d     = DIV_DONE;
                    end else begin
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = DIV_IDLE;
                end else begin
                    prem_d = prem_step;
                    dvd_d  = dvd_step;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        quotient_d  = cond_neg(dvd_step, q_neg_q);
                        remainder_d = cond_neg(prem_step, r_neg_q);
                        state_d     = DIV_DONE;
                    end
                end
            end
            DIV_DONE: state_d = DIV_IDLE;  // a start held here belongs to the retiring instruction
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q == DIV_BUSY);
        ready     = (state_q == DIV_DONE) && !cancel;
        stallreq  = ((state_q == DIV_IDLE) && start && !cancel) || (state_q == DIV_BUSY);
        quotient  = quotient_q;
        remainder = remainder_q;
    end

endmodule

// File: tb/tb_iter_div.sv
// Directed test bench for iter_div. It uses a WIDTH=32 and a WIDTH=8 instance on a shared clock.
// Inputs are driven and outputs are sampled on the falling edge. Cycle 0 is the cycle in which start is presented.
module tb_iter_div;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, signed_op, cancel;
    logic [31:0] dividend, divisor;
    logic        busy, ready, stallreq;
    logic [31:0] quotient, remainder;

    logic        rst8, start8, signed8, cancel8;
    logic [7:0]  dividend8, divisor8;
    logic        busy8, ready8, stallreq8;
    logic [7:0]  quotient8, remainder8;

    int checks = 0;
    int errors = 0;

    iter_div #(.WIDTH(32)) u_div32 (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .cancel(cancel),
        .dividend(dividend), .divisor(divisor), .busy(busy), .ready(ready),
        .stallreq(stallreq), .quotient(quotient), .remainder(remainder)
    );

    iter_div #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst(rst8), .start(start8), .signed_op(signed8), .cancel(cancel8),
        .dividend(dividend8), .divisor(divisor8), .busy(busy8), .ready(ready8),
        .stallreq(stallreq8), .quotient(quotient8), .remainder(remainder8)
    );

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        dividend  = a;
        divisor   = b;
        signed_op = sgn;
        cancel    = 1'b0;
        start     = 1'b1;
    endtask

    // Call this at the falling edge of cycle 0, after drive32. It returns at the
    // falling edge of the ready cycle, or one cycle later when drop is set.
    task automatic wait_done32(input string name, input logic [31:0] eq, input logic [31:0] er,
                               input int elat, input bit drop);
        int lat;
        int stall_bad;
        lat = -1;
        stall_bad = 0;
        #1;
        checks++;
        if (stallreq !== 1'b1) begin
            errors++;
            $display("FAIL %s stallreq_c0: got %b expected 1", name, stallreq);
        end
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = n;
                break;
            end
            if (stallreq !== 1'b1) stall_bad++;
        end
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL %s stallreq_busy: %0d low cycles expected 0", name, stall_bad);
        end
        checks++;
        if (quotient !== eq) begin
            errors++;
            $display("FAIL %s quotient: got %h expected %h", name, quotient, eq);
        end
        checks++;
        if (remainder !== er) begin
            errors++;
            $display("FAIL %s remainder: got %h expected %h", name, remainder, er);
        end
        checks++;
        if (stallreq !== 1'b0) begin
            errors++;
            $display("FAIL %s stallreq_done: got %b expected 0", name, stallreq);
        end
        if (drop) begin
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done: ready=%b busy=%b expected 0 0", name, ready, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; cancel = 1'b0; dividend = '0; divisor = '0;
        rst8 = 1'b1; start8 = 1'b0; signed8 = 1'b0; cancel8 = 1'b0; dividend8 = '0; divisor8 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, ready, stallreq, quotient, remainder} !== 67'd0) begin
            errors++;
            $display("FAIL reset32: busy=%b ready=%b stall=%b q=%h r=%h expected all 0",
                     busy, ready, stallreq, quotient, remainder);
        end
        checks++;
        if ({busy8, ready8, stallreq8, quotient8, remainder8} !== 19'd0) begin
            errors++;
            $display("FAIL reset8: busy=%b ready=%b stall=%b q=%h r=%h expected all 0",
                     busy8, ready8, stallreq8, quotient8, remainder8);
        end
        rst = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        drive32(32'd7, 32'd2, 1'b0);
        wait_done32("u7div2", 32'd3, 32'd1, 33, 1'b1);
        drive32(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_done32("uffdiv1", 32'hFFFF_FFFF, 32'd0, 33, 1'b1);
    endtask

    task automatic test_signed();
        drive32(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done32("sm7div2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b1);
        drive32(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done32("s7divm2", 32'hFFFF_FFFD, 32'd1, 33, 1'b1);
        drive32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done32("soverflow", 32'h8000_0000, 32'd0, 33, 1'b1);
    endtask

    task automatic test_div_zero();
        drive32(32'd5, 32'd0, 1'b0);
        wait_done32("u5div0", 32'hFFFF_FFFF, 32'd5, 1, 1'b1);
        drive32(32'd5, 32'd0, 1'b1);
        wait_done32("s5div0", 32'hFFFF_FFFF, 32'd5, 1, 1'b1);
        drive32(32'hFFFF_FFFB, 32'd0, 1'b1);
        wait_done32("sm5div0", 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 1'b1);
    endtask

    task automatic test_cancel();
        int pulses;
        drive32(32'd7, 32'd2, 1'b0);
        wait_done32("c_pre", 32'd3, 32'd1, 33, 1'b1);
        drive32(32'd1000, 32'd3, 1'b0);
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (ready === 1'b1) pulses++;
        end
        // cycle 10: flush arrives
        start  = 1'b0;
        cancel = 1'b1;
        #1;
        if (ready === 1'b1) pulses++;
        @(negedge clk);  // cycle 11
        if (ready === 1'b1) pulses++;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_busy: got %b expected 0", busy);
        end
        checks++;
        if (quotient !== 32'd3 || remainder !== 32'd1) begin
            errors++;
            $display("FAIL cancel_hold: got q=%h r=%h expected 3 1", quotient, remainder);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL cancel_ready: got %0d pulses expected 0", pulses);
        end
        cancel = 1'b0;
        @(negedge clk);  // cycle 12
        drive32(32'd100, 32'd7, 1'b0);
        wait_done32("c_after", 32'd14, 32'd2, 33, 1'b1);
        // cancel with start in IDLE: the start must be blocked
        start  = 1'b1;
        cancel = 1'b1;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle_stall: got %b expected 0", stallreq);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle_block: busy=%b ready=%b expected 0 0", busy, ready);
        end
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive32(32'd9, 32'd4, 1'b0);
        wait_done32("b2b_first", 32'd2, 32'd1, 33, 1'b0);
        // Start stays high. New operands appear in the DONE cycle and must be
        // accepted in the following IDLE cycle.
        drive32(32'd50, 32'd6, 1'b0);
        @(negedge clk);
        wait_done32("b2b_second", 32'd8, 32'd2, 33, 1'b1);
    endtask

    task automatic test_w8();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vs [3];
        logic [7:0] vq [3];
        logic [7:0] vr [3];
        int lat;
        va = '{8'd200, 8'h80, 8'hF9};
        vb = '{8'd7,   8'hFF, 8'h02};
        vs = '{1'b0,   1'b1,  1'b1};
        vq = '{8'd28,  8'h80, 8'hFD};
        vr = '{8'd4,   8'h00, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            dividend8 = va[i]; divisor8 = vb[i]; signed8 = vs[i]; start8 = 1'b1;
            lat = -1;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (ready8 === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            checks++;
            if (lat != 9 || quotient8 !== vq[i] || remainder8 !== vr[i]) begin
                errors++;
                $display("FAIL w8_vec%0d: lat=%0d q=%h r=%h expected 9 %h %h",
                         i, lat, quotient8, remainder8, vq[i], vr[i]);
            end
            start8 = 1'b0;
            @(negedge clk);
        end

        // cancel in DONE: the result is already written, but the ready pulse is suppressed
        dividend8 = 8'd50; divisor8 = 8'd5; signed8 = 1'b0; start8 = 1'b1;
        repeat (8) @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        #1 cancel8 = 1'b1;
        @(negedge clk);  // cycle 9 (DONE)
        checks++;
        if (ready8 !== 1'b0 || quotient8 !== 8'd10 || remainder8 !== 8'd0) begin
            errors++;
            $display("FAIL w8_cancel_done: ready=%b q=%h r=%h expected 0 0a 00", ready8, quotient8, remainder8);
        end
        @(negedge clk);
        cancel8 = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || ready8 !== 1'b0) begin
            errors++;
            $display("FAIL w8_cancel_idle: busy=%b ready=%b expected 0 0", busy8, ready8);
        end

        // reset mid-operation
        dividend8 = 8'd100; divisor8 = 8'd3; signed8 = 1'b0; start8 = 1'b1;
        repeat (4) @(negedge clk);  // cycle 4
        rst8   = 1'b1;
        start8 = 1'b0;
        @(negedge clk);  // cycle 5
        checks++;
        if ({busy8, ready8, stallreq8, quotient8, remainder8} !== 19'd0) begin
            errors++;
            $display("FAIL w8_reset: busy=%b ready=%b stall=%b q=%h r=%h expected all 0",
                     busy8, ready8, stallreq8, quotient8, remainder8);
        end
        rst8 = 1'b0;
        lat = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ready8 === 1'b1 || busy8 === 1'b1) lat++;
        end
        checks++;
        if (lat != 0) begin
            errors++;
            $display("FAIL w8_reset_quiet: got %0d active cycles expected 0", lat);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_w8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
